// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle execution unit for the RV32M operations. One request is in
//   flight at a time. Multiplies use a 32-step shift-add on magnitudes, and
//   divides/remainders use a 32-step restoring divider. The sign is applied
//   in a final fix-up cycle. Divide-by-zero and signed overflow return the
//   architectural RISC-V results without running the iterative datapath.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   reset      in   synchronous active-high reset; overrides everything
//   in_valid   in   request strobe
//   in_ready   out  high only while idle
//   funct      in   10 mul, 11 mulh, 12 mulhsu, 13 mulhu,
//                   14 div, 15 divu, 16 rem, 17 remu
//   op_a       in   rs1 operand
//   op_b       in   rs2 operand
//   flush      in   abandon the operation in flight
//   out_valid  out  result available; held until out_ready
//   out_ready  in   consumer takes the result
//   result     out  result word; stable while out_valid
//   illegal    out  funct outside 10..17; qualified by out_valid
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      funct,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_result;
    logic                r_illegal;
    logic [CW-1:0]       r_cnt;

    // Operation captured at accept.
    logic [4:0]          r_funct;
    logic [XLEN-1:0]     r_op_a;
    logic [XLEN-1:0]     r_op_b;

    // Iterative datapath.
    logic                r_neg;     // negate the final magnitude
    logic [XLEN-1:0]     r_b_abs;   // divisor magnitude
    logic [2*XLEN-1:0]   r_acc;     // product accumulator
    logic [2*XLEN-1:0]   r_mcand;   // multiplicand, shifted left each step
    logic [XLEN-1:0]     r_q;       // multiplier (mul) or dividend/quotient (div)
    logic [XLEN-1:0]     r_rem;     // partial remainder

    function automatic logic [XLEN-1:0] f_cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Decode of the captured funct.
    logic w_legal, w_is_mul, w_is_div, w_is_rem, w_sgn_a, w_sgn_b;

    always_comb begin
        w_legal  = 1'b1;
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        w_is_rem = 1'b0;
        w_sgn_a  = 1'b0;
        w_sgn_b  = 1'b0;
        case (r_funct)
            5'd10, 5'd11: begin w_is_mul = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            5'd12:        begin w_is_mul = 1'b1; w_sgn_a = 1'b1; end
            5'd13:        begin w_is_mul = 1'b1; end
            5'd14:        begin w_is_div = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            5'd15:        begin w_is_div = 1'b1; end
            5'd16:        begin w_is_rem = 1'b1; w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            5'd17:        begin w_is_rem = 1'b1; end
            default:      begin w_legal = 1'b0; end
        endcase
    end

    logic signed [XLEN-1:0] w_a_s, w_b_s;
    logic                   w_neg_a, w_neg_b, w_neg, w_b_zero, w_ovf;
    logic [XLEN-1:0]        w_a_abs, w_b_abs;

    assign w_a_s    = r_op_a;
    assign w_b_s    = r_op_b;
    assign w_neg_a  = w_sgn_a && (w_a_s < 0);
    assign w_neg_b  = w_sgn_b && (w_b_s < 0);
    assign w_a_abs  = f_cond_neg(r_op_a, w_neg_a);
    assign w_b_abs  = f_cond_neg(r_op_b, w_neg_b);
    // Remainder takes the dividend's sign; product and quotient take sa^sb.
    assign w_neg    = w_is_rem ? w_neg_a : (w_neg_a ^ w_neg_b);
    assign w_b_zero = (r_op_b == '0);
    // Only the signed divide/remainder can overflow (MIN / -1).
    assign w_ovf    = w_sgn_b && !w_is_mul && (r_op_a == MIN_NEG) && (r_op_b == ALL_ONE);

    // Restoring step: bring in the next dividend bit, subtract if it fits.
    logic [XLEN:0] w_rem_sh;
    logic          w_ge;

    assign w_rem_sh = {r_rem, r_q[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b_abs});

    // Sign fix-up of the finished magnitudes.
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_q_fix, w_r_fix;

    assign w_prod_fix = f_cond_neg2(r_acc, r_neg);
    assign w_q_fix    = f_cond_neg(r_q, r_neg);
    assign w_r_fix    = f_cond_neg(r_rem, r_neg);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
        end else if (flush && (r_state != S_IDLE)) begin
            // Flush beats a same-cycle out_ready: the result is dropped.
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_funct    <= funct;
                        r_op_a     <= op_a;
                        r_op_b     <= op_b;
                        r_in_ready <= 1'b0;
                        r_state    <= S_PREP;
                    end
                end

                S_PREP: begin
                    r_neg   <= w_neg;
                    r_b_abs <= w_b_abs;
                    r_acc   <= '0;
                    r_mcand <= {{XLEN{1'b0}}, w_a_abs};
                    r_rem   <= '0;
                    r_q     <= w_is_mul ? w_b_abs : w_a_abs;
                    r_cnt   <= '0;
                    if (!w_legal) begin
                        r_result    <= '0;
                        r_illegal   <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (!w_is_mul && (w_b_zero || w_ovf)) begin
                        // Divide by zero: quotient all ones, remainder = dividend.
                        // Overflow: quotient = MIN, remainder = 0.
                        if (w_b_zero)
                            r_result <= w_is_div ? ALL_ONE : r_op_a;
                        else
                            r_result <= w_is_div ? MIN_NEG : '0;
                        r_illegal   <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_CALC;
                    end
                end

                S_CALC: begin
                    if (w_is_mul) begin
                        if (r_q[0])
                            r_acc <= r_acc + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_q     <= r_q >> 1;
                    end else begin
                        r_rem <= w_ge ? XLEN'(w_rem_sh - {1'b0, r_b_abs}) : w_rem_sh[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], w_ge};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST)
                        r_state <= S_FIX;
                end

                S_FIX: begin
                    case (r_funct)
                        5'd10:               r_result <= w_prod_fix[XLEN-1:0];
                        5'd11, 5'd12, 5'd13: r_result <= w_prod_fix[2*XLEN-1:XLEN];
                        5'd14, 5'd15:        r_result <= w_q_fix;
                        default:             r_result <= w_r_fix;
                    endcase
                    r_illegal   <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed vectors with literal expectations
// plus a behavioural reference model checked against the DUT every cycle.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: RISC-V M semantics with plain 64-bit arithmetic, plus the
    // cycle at which the result must appear (2 for early-outs, 35 otherwise).
    function automatic void model_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic ill, output int lat);
        longint sa, sb, ub, q;
        logic [63:0] p, ua, ubb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ub  = longint'({32'b0, b});
        ua  = {32'b0, a};
        ubb = {32'b0, b};
        res = 32'h0;
        ill = 1'b0;
        lat = 35;
        case (f)
            5'd10: begin p = 64'(sa * sb); res = p[31:0];  end
            5'd11: begin p = 64'(sa * sb); res = p[63:32]; end
            5'd12: begin p = 64'(sa * ub); res = p[63:32]; end
            5'd13: begin p = ua * ubb;     res = p[63:32]; end
            5'd14, 5'd16: begin
                if (b == 32'h0) begin
                    res = (f == 5'd14) ? 32'hFFFF_FFFF : a;
                    lat = 2;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    res = (f == 5'd14) ? 32'h8000_0000 : 32'h0;
                    lat = 2;
                end else begin
                    q = (f == 5'd14) ? (sa / sb) : (sa % sb);
                    p = 64'(q);
                    res = p[31:0];
                end
            end
            5'd15: begin
                if (b == 32'h0) begin res = 32'hFFFF_FFFF; lat = 2; end
                else res = a / b;
            end
            5'd17: begin
                if (b == 32'h0) begin res = a; lat = 2; end
                else res = a % b;
            end
            default: begin ill = 1'b1; lat = 2; end
        endcase
    endfunction

    // Model of the visible handshake: busy from accept until consumed,
    // flushed or reset; output valid from the latency point onward.
    logic        m_busy = 1'b0;
    int          m_cyc  = 0;
    int          m_lat  = 35;
    logic [31:0] m_res  = 32'h0;
    logic        m_ill  = 1'b0;
    logic        cmp_en = 1'b0;

    always @(posedge clk) begin
        logic vld_now;
        vld_now = m_busy && (m_cyc >= m_lat - 1);
        if (reset) begin
            m_busy = 1'b0;
        end else if (m_busy && flush) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_cyc  = 0;
                model_op(funct, op_a, op_b, m_res, m_ill, m_lat);
            end
        end else if (vld_now && out_ready) begin
            m_busy = 1'b0;
        end else begin
            m_cyc++;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic m_vld;
            m_vld = m_busy && (m_cyc >= m_lat - 1);
            chk1("cmp_in_ready", in_ready, !m_busy);
            chk1("cmp_out_valid", out_valid, m_vld);
            if (m_vld) begin
                chk("cmp_result", result, m_res);
                chk1("cmp_illegal", illegal, m_ill);
            end
        end
    end

    // Present one request at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b, input logic fl);
        in_valid = 1'b1;
        funct    = f;
        op_a     = a;
        op_b     = b;
        flush    = fl;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        funct    = 5'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic run_op(input string nm, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_i, input int exp_lat,
                          input int hold, input logic fl);
        logic [31:0] mr;
        logic        mi;
        int          ml;
        int          j;
        logic [31:0] first;
        model_op(f, a, b, mr, mi, ml);
        chk({nm, "_model_res"}, mr, exp_r);
        chk({nm, "_model_lat"}, 32'(ml), 32'(exp_lat));
        issue(f, a, b, fl);
        j = 0;
        while (!out_valid && j < 60) begin
            @(negedge clk);
            j++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: out_valid low after %0d cycles, required by cycle %0d", nm, j, exp_lat);
        end else begin
            chk({nm, "_latency"}, 32'(j + 1), 32'(exp_lat));
            chk({nm, "_result"}, result, exp_r);
            chk1({nm, "_illegal"}, illegal, exp_i);
            first = result;
            repeat (hold) @(negedge clk);
            if (hold > 0) begin
                chk({nm, "_held"}, result, first);
                chk1({nm, "_held_vld"}, out_valid, 1'b1);
                chk1({nm, "_held_rdy"}, in_ready, 1'b0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk1({nm, "_idle"}, in_ready, 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        funct     = 5'd0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk1("rst_illegal", illegal, 1'b0);
        @(negedge clk);

        // Multiply family.
        run_op("mul_7_m3",   5'd10, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 35, 0, 1'b0);
        run_op("mulh_m1",    5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 35, 0, 1'b0);
        run_op("mulhsu_m1",  5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 35, 0, 1'b0);
        run_op("mulhu_m1",   5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 35, 0, 1'b0);
        run_op("mulh_min",   5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 35, 0, 1'b0);

        // Divide family.
        run_op("div_m7_2",   5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 35, 0, 1'b0);
        run_op("rem_m7_2",   5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 35, 0, 1'b0);
        run_op("divu_100_7", 5'd15, 32'd100,       32'd7,         32'd14,        1'b0, 35, 0, 1'b0);
        run_op("remu_100_7", 5'd17, 32'd100,       32'd7,         32'd2,         1'b0, 35, 0, 1'b0);

        // Early-outs.
        run_op("div_by0",    5'd14, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0, 2, 0, 1'b0);
        run_op("rem_by0",    5'd16, 32'd5,         32'd0,         32'd5,         1'b0, 2, 0, 1'b0);
        run_op("divu_by0",   5'd15, 32'd9,         32'd0,         32'hFFFF_FFFF, 1'b0, 2, 0, 1'b0);
        run_op("remu_by0",   5'd17, 32'd9,         32'd0,         32'd9,         1'b0, 2, 0, 1'b0);
        run_op("div_ovf",    5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 2, 0, 1'b0);
        run_op("rem_ovf",    5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2, 0, 1'b0);
        run_op("illegal_f3", 5'd3,  32'd12,        32'd34,        32'h0000_0000, 1'b1, 2, 0, 1'b0);

        // Backpressure: result held for 5 cycles with out_ready low.
        run_op("mul_bp",     5'd10, 32'd1234,      32'd5678,      32'h006A_E9BC, 1'b0, 35, 5, 1'b0);

        // Reset sampled at N+10 while iterating.
        issue(5'd10, 32'd3, 32'd4, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", result, 32'h0);

        // Flush sampled at N+20; the next op must be unaffected.
        issue(5'd14, 32'd1000, 32'd3, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk1("flush_in_ready", in_ready, 1'b1);
        chk1("flush_out_valid", out_valid, 1'b0);
        run_op("after_flush", 5'd15, 32'd100, 32'd7, 32'd14, 1'b0, 35, 0, 1'b0);

        // Flush in DONE together with out_ready: result dropped, back to idle.
        issue(5'd14, 32'd5, 32'd0, 1'b0);
        @(negedge clk);
        chk1("done_vld", out_valid, 1'b1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk1("doneflush_out_valid", out_valid, 1'b0);
        chk1("doneflush_in_ready", in_ready, 1'b1);

        // Flush while idle does not block a same-cycle request.
        run_op("idle_flush", 5'd17, 32'd100, 32'd7, 32'd2, 1'b0, 35, 0, 1'b1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
